// File: rtl/dma_irq_coalesce.sv
// dma_irq_coalesce
// Coalesces single-cycle DMA completion pulses into one level interrupt.
// A window opens on the first completion and fires when the completion
// count reaches the effective threshold or the window timer expires.
// While the interrupt is pending, further completions are collected in a
// shadow counter and seed the next window once software acknowledges.
module dma_irq_coalesce #(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned TimerWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  evt_i,
  input  logic                  cfg_en_i,
  input  logic [CntWidth-1:0]   cfg_thresh_i,
  input  logic [TimerWidth-1:0] cfg_timeout_i,
  input  logic                  ack_i,
  output logic                  irq_o,
  output logic [CntWidth-1:0]   pending_cnt_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0]   CntMax = '1;
  localparam logic [CntWidth-1:0]   CntOne = CntWidth'(1);
  localparam logic [TimerWidth-1:0] TmrMax = '1;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [CntWidth-1:0]   shadow_q, shadow_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  irq_q, irq_d;
  logic                  ovf_q, ovf_d;

  // Effective configuration, re-evaluated every cycle so that a change
  // mid-window takes effect at the very next compare.
  logic [CntWidth-1:0] thr;
  logic                timer_active;

  assign thr          = (!cfg_en_i || (cfg_thresh_i == '0)) ? CntOne : cfg_thresh_i;
  assign timer_active = cfg_en_i && (cfg_timeout_i != '0);

  // Sums are formed one bit wider so that saturation can be detected from
  // the carry instead of letting the counters wrap.
  logic [CntWidth:0]     cnt_sum;
  logic [CntWidth:0]     shadow_sum;
  logic [TimerWidth:0]   timer_sum;
  logic [CntWidth-1:0]   cnt_inc;
  logic [CntWidth-1:0]   shadow_inc;
  logic [TimerWidth-1:0] timer_inc;
  logic                  shadow_full;
  logic                  timeout_hit;

  assign cnt_sum     = {1'b0, cnt_q}    + (CntWidth+1)'(evt_i);
  assign shadow_sum  = {1'b0, shadow_q} + (CntWidth+1)'(evt_i);
  assign timer_sum   = {1'b0, timer_q}  + (TimerWidth+1)'(1);

  assign cnt_inc     = cnt_sum[CntWidth]      ? CntMax : cnt_sum[CntWidth-1:0];
  assign shadow_inc  = shadow_sum[CntWidth]   ? CntMax : shadow_sum[CntWidth-1:0];
  assign timer_inc   = timer_sum[TimerWidth]  ? TmrMax : timer_sum[TimerWidth-1:0];

  // An event arriving while the shadow counter is already full is the one
  // that would have pushed the next window's count past its maximum.
  assign shadow_full = shadow_sum[CntWidth];

  // The timer compare uses the wide sum, so a saturated timer still meets
  // any non-zero timeout and the window is guaranteed to close.
  assign timeout_hit = timer_active && (timer_sum >= {1'b0, cfg_timeout_i});

  // Next-state and next-output logic for the coalescing window.
  // NOTE: every target gets a hold/default value before the case statement;
  // a path that skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    timer_d  = timer_q;
    irq_d    = irq_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (evt_i) begin
          cnt_d    = CntOne;
          timer_d  = '0;
          shadow_d = '0;
          if (thr == CntOne) begin
            state_d = FIRE;
            irq_d   = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        timer_d = timer_inc;
        cnt_d   = cnt_inc;
        if ((cnt_inc >= thr) || timeout_hit) begin
          state_d  = FIRE;
          irq_d    = 1'b1;
          shadow_d = '0;
        end
      end

      FIRE: begin
        // cnt stays frozen so software sees a stable drain count.
        irq_d    = 1'b1;
        shadow_d = shadow_inc;
        if (shadow_full) begin
          ovf_d = 1'b1;
        end
        if (ack_i) begin
          irq_d = 1'b0;
          ovf_d = 1'b0;
          // An event coinciding with the acknowledge opens the next window.
          if (shadow_sum == '0) begin
            state_d  = IDLE;
            cnt_d    = '0;
            shadow_d = '0;
          end else begin
            // If the carried-over count already meets the threshold, the
            // ACCUM compare fires again on the following edge.
            state_d  = ACCUM;
            cnt_d    = shadow_inc;
            shadow_d = '0;
            timer_d  = '0;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        shadow_d = '0;
        timer_d  = '0;
        irq_d    = 1'b0;
        ovf_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any pending events.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      timer_q  <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      timer_q  <= timer_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
    end
  end

  assign irq_o         = irq_q;
  assign pending_cnt_o = cnt_q;
  assign overflow_o    = ovf_q;

endmodule
